// File: rtl/i2cmb_cmd_sequencer.sv
// Wishbone master that sequences i2cmb register accesses to run one I2C transaction per request.
// Define I2CMB_SEQ_POLL_EN to poll CMDR for completion instead of waiting on irq_i.
module i2cmb_cmd_sequencer #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned BUS_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rw_i,
    input  logic [BUS_W-1:0] req_bus_i,
    input  logic [6:0]       req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [1:0]       wb_adr_o,
    output logic [7:0]       wb_dat_o,
    input  logic [7:0]       wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             irq_i
);

`ifdef I2CMB_SEQ_POLL_EN
    localparam logic [7:0] CsrInit = 8'h80;
`else
    localparam logic [7:0] CsrInit = 8'hC0;
`endif

    typedef enum logic [3:0] {
        StInit, StIdle, StDpr, StCmd, StWait, StRdCmdr, StBusy, StDecode, StRdDpr, StRdOut, StDone
    } state_e;

    typedef enum logic [2:0] {
        StepSetBus, StepStart, StepAddr, StepWrite, StepRead, StepStop
    } step_e;

    state_e           state_q, state_d, ret_q, ret_d;
    step_e            step_q, step_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic [6:0]       addr_q, addr_d;
    logic [1:0]       stat_q, stat_d, status_q, status_d;
    logic [7:0]       rdat_q, rdat_d;
    logic             cyc_q, cyc_d, we_q, we_d;
    logic [1:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;

    logic             launch, l_we, pending;
    logic [1:0]       l_adr;
    logic [7:0]       l_dat, cmd;
    state_e           l_ret;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StInit;
            ret_q    <= StIdle;
            step_q   <= StepSetBus;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            bus_q    <= '0;
            addr_q   <= '0;
            stat_q   <= 2'b00;
            status_q <= 2'b00;
            rdat_q   <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            bus_q    <= bus_d;
            addr_q   <= addr_d;
            stat_q   <= stat_d;
            status_q <= status_d;
            rdat_q   <= rdat_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        case (step_q)
            StepSetBus: cmd = 8'h06;
            StepStart:  cmd = 8'h04;
            StepRead:   cmd = (cnt_q == LEN_W'(1)) ? 8'h03 : 8'h02;
            StepStop:   cmd = 8'h05;
            default:    cmd = 8'h01;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ret_d = ret_q;
        step_d = step_q;
        cnt_d = cnt_q;
        rw_d = rw_q;
        bus_d = bus_q;
        addr_d = addr_q;
        stat_d = stat_q;
        status_d = status_q;
        rdat_d = rdat_q;
        cyc_d = cyc_q;
        we_d = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        launch = 1'b0;
        l_we = 1'b0;
        l_adr = 2'd0;
        l_dat = 8'h00;
        l_ret = StIdle;
        pending = 1'b0;
        req_ready_o = 1'b0;
        wr_ready_o = 1'b0;
        rd_valid_o = 1'b0;
        done_o = 1'b0;

        case (state_q)
            StInit: begin
                launch = 1'b1; l_we = 1'b1; l_adr = 2'd0; l_dat = CsrInit; l_ret = StIdle;
            end
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    rw_d = req_rw_i;
                    bus_d = req_bus_i;
                    addr_d = req_addr_i;
                    cnt_d = req_len_i;
                    stat_d = 2'b00;
                    step_d = StepSetBus;
                    state_d = StDpr;
                end
            end
            StDpr: begin
                case (step_q)
                    StepSetBus: begin
                        launch = 1'b1; l_we = 1'b1; l_adr = 2'd1; l_dat = 8'(bus_q); l_ret = StCmd;
                    end
                    StepAddr: begin
                        launch = 1'b1; l_we = 1'b1; l_adr = 2'd1; l_dat = {addr_q, rw_q};
                        l_ret = StCmd;
                    end
                    StepWrite: begin
                        if (wr_valid_i) begin
                            wr_ready_o = 1'b1;
                            launch = 1'b1; l_we = 1'b1; l_adr = 2'd1; l_dat = wr_data_i;
                            l_ret = StCmd;
                        end
                    end
                    default: state_d = StCmd;
                endcase
            end
            StCmd: begin
                launch = 1'b1; l_we = 1'b1; l_adr = 2'd2; l_dat = cmd; l_ret = StWait;
            end
            StWait: begin
`ifdef I2CMB_SEQ_POLL_EN
                state_d = StRdCmdr;
`else
                if (irq_i) state_d = StRdCmdr;
`endif
            end
            StRdCmdr: begin
                launch = 1'b1; l_we = 1'b0; l_adr = 2'd2; l_ret = StDecode;
            end
            StBusy: begin
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    we_d = 1'b0;
                    adr_d = 2'd0;
                    dat_d = 8'h00;
                    if (!we_q) rdat_d = wb_dat_i;
                    state_d = ret_q;
                end
            end
            StDecode: begin
`ifdef I2CMB_SEQ_POLL_EN
                pending = (rdat_q[7:4] == 4'h0);
`endif
                // Losing the bus or a core error means we no longer own it: skip STOP.
                if (rdat_q[5] || rdat_q[4]) begin
                    stat_d = 2'b11;
                    state_d = StDone;
                end else if (pending) begin
                    state_d = StRdCmdr;
                end else begin
                    state_d = StDpr;
                    case (step_q)
                        StepSetBus: step_d = StepStart;
                        StepStart:  step_d = StepAddr;
                        StepAddr: begin
                            if (rdat_q[6]) begin
                                stat_d = 2'b01;
                                step_d = StepStop;
                            end else if (cnt_q == '0) begin
                                step_d = StepStop;
                            end else begin
                                step_d = rw_q ? StepRead : StepWrite;
                            end
                        end
                        StepWrite: begin
                            if (rdat_q[6]) begin
                                stat_d = 2'b10;
                                step_d = StepStop;
                            end else begin
                                if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
                                step_d = (cnt_q == LEN_W'(1)) ? StepStop : StepWrite;
                            end
                        end
                        StepRead: state_d = StRdDpr;
                        default:  state_d = StDone;
                    endcase
                end
            end
            StRdDpr: begin
                launch = 1'b1; l_we = 1'b0; l_adr = 2'd1; l_ret = StRdOut;
            end
            StRdOut: begin
                rd_valid_o = 1'b1;
                if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
                step_d = (cnt_q == LEN_W'(1)) ? StepStop : StepRead;
                state_d = StDpr;
            end
            StDone: begin
                done_o = 1'b1;
                status_d = stat_q;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        if (launch) begin
            cyc_d = 1'b1;
            we_d = l_we;
            adr_d = l_adr;
            dat_d = l_dat;
            ret_d = l_ret;
            state_d = StBusy;
        end
    end

    assign status_o  = (state_q == StDone) ? stat_q : status_q;
    assign rd_data_o = rdat_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Directed bench for i2cmb_cmd_sequencer with a behavioural i2cmb slave and scoreboard queues.
module tb_i2cmb_cmd_sequencer;

`ifdef I2CMB_SEQ_POLL_EN
    localparam logic [7:0] CsrInit = 8'h80;
`else
    localparam logic [7:0] CsrInit = 8'hC0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [3:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_len = '0;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic [1:0] status;
    logic       wb_cyc, wb_stb, wb_we;
    logic [1:0] wb_adr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_rdat = '0;
    logic       wb_ack = 1'b0;
    logic       irq = 1'b0;

    always #5 clk = ~clk;

    i2cmb_cmd_sequencer #(.LEN_W(8), .BUS_W(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_len_i(req_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .done_o(done), .status_o(status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_rdat), .wb_ack_i(wb_ack), .irq_i(irq)
    );

    // Byte sources written by the stimulus, consumed via monitor-owned pointers.
    logic [7:0] wr_src [0:15];
    logic [7:0] rd_src [0:15];
    int         wr_cnt = 0, rd_cnt = 0;
    logic       wr_en = 1'b0;
    int         sp_idx = -1;
    logic [7:0] sp_val = 8'h80;

    // Monitor/slave-owned state.
    int         wr_ptr = 0, rd_ptr = 0, ncmd = 0, irq_cd = 0, rdy_cnt = 0;
    logic       hs_pend = 1'b0;
    logic       cap_we = 1'b0;
    logic [1:0] cap_adr = '0;
    logic [7:0] cap_dat = '0, cur_resp = 8'h80;
    logic [9:0] obs_wr [$];
    logic [7:0] obs_rd [$];
    logic [1:0] obs_st [$];

    assign wr_valid = wr_en && (wr_ptr < wr_cnt);
    assign wr_data  = wr_src[wr_ptr[3:0]];

    always @(negedge clk) begin
        if (!rst_n) begin
            wb_ack = 1'b0;
            irq = 1'b0;
            irq_cd = 0;
            hs_pend = 1'b0;
        end else begin
            if (hs_pend) begin
                wr_ptr = wr_ptr + 1;
                hs_pend = 1'b0;
            end
            if (wr_ready) rdy_cnt = rdy_cnt + 1;
            if (wr_ready && wr_valid) hs_pend = 1'b1;
            if (irq_cd > 0) begin
                irq_cd = irq_cd - 1;
                if (irq_cd == 0) irq = 1'b1;
            end
            if (wb_ack) begin
                wb_ack = 1'b0;
                if (cap_we) begin
                    obs_wr.push_back({cap_adr, cap_dat});
                    if (cap_adr == 2'd2) begin
                        cur_resp = (ncmd == sp_idx) ? sp_val : 8'h80;
                        ncmd = ncmd + 1;
                        irq_cd = 3;
                    end
                end else if (cap_adr == 2'd2) begin
                    irq = 1'b0;
                end
            end else if (wb_cyc && wb_stb) begin
                wb_ack = 1'b1;
                cap_we = wb_we;
                cap_adr = wb_adr;
                cap_dat = wb_dat_o;
                if (wb_adr == 2'd2) wb_rdat = cur_resp;
                else if (wb_adr == 2'd1 && !wb_we) begin
                    wb_rdat = (rd_ptr < rd_cnt) ? rd_src[rd_ptr[3:0]] : 8'hEE;
                    rd_ptr = rd_ptr + 1;
                end else wb_rdat = 8'h00;
            end
            if (rd_valid) obs_rd.push_back(rd_data);
            if (done) obs_st.push_back(status);
        end
    end

    // Scoreboard: expectations are queued as stimulus is issued.
    logic [9:0] exp_wr [$];
    logic [7:0] exp_rd [$];
    int         owp = 0, orp = 0, osp = 0;
    int         n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ew(input logic [1:0] adr, input logic [7:0] dat);
        exp_wr.push_back({adr, dat});
    endtask

    task automatic cmp_writes(input string name);
        logic [9:0] e;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (owp < obs_wr.size()) check($sformatf("%s_wr%0d", name, owp), obs_wr[owp], e);
            else check($sformatf("%s_wr_missing", name), obs_wr.size(), owp + 1);
            owp = owp + 1;
        end
        check($sformatf("%s_wr_count", name), obs_wr.size(), owp);
        owp = obs_wr.size();
    endtask

    task automatic cmp_reads(input string name);
        logic [7:0] e;
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            if (orp < obs_rd.size()) check($sformatf("%s_rd%0d", name, orp), obs_rd[orp], e);
            else check($sformatf("%s_rd_missing", name), obs_rd.size(), orp + 1);
            orp = orp + 1;
        end
        check($sformatf("%s_rd_count", name), obs_rd.size(), orp);
        orp = obs_rd.size();
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        check($sformatf("%s_ready", name), req_ready, 1'b1);
    endtask

    task automatic issue(input string name, input logic rw, input logic [3:0] bus,
                         input logic [6:0] addr, input logic [7:0] len);
        @(negedge clk);
        req_rw = rw; req_bus = bus; req_addr = addr; req_len = len;
        req_valid = 1'b1;
        wait_ready(name);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check($sformatf("%s_ready_drop", name), req_ready, 1'b0);
    endtask

    task automatic finish_txn(input string name, input logic [1:0] exp_st);
        int n = 0;
        while (obs_st.size() <= osp && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (6) @(negedge clk);
        check($sformatf("%s_done_count", name), obs_st.size(), osp + 1);
        if (obs_st.size() > osp) check($sformatf("%s_status", name), obs_st[osp], exp_st);
        check($sformatf("%s_status_held", name), status, exp_st);
        osp = obs_st.size();
        cmp_writes(name);
        cmp_reads(name);
    endtask

    initial begin
        int base, n, rdy0;
        #3;
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        ew(2'd0, CsrInit);
        wait_ready("init");
        repeat (3) @(negedge clk);
        cmp_writes("init");

        // Write bus 2, addr 0x22, two bytes, all ACKed.
        wr_src[0] = 8'hA5; wr_src[1] = 8'h3C; wr_cnt = 2; wr_en = 1'b1;
        ew(1, 8'h02); ew(2, 8'h06); ew(2, 8'h04); ew(1, 8'h44); ew(2, 8'h01);
        ew(1, 8'hA5); ew(2, 8'h01); ew(1, 8'h3C); ew(2, 8'h01); ew(2, 8'h05);
        issue("wr2", 1'b0, 4'd2, 7'h22, 8'd2);
        finish_txn("wr2", 2'b00);
        check("wr2_consumed", wr_ptr, 2);

        // Read three bytes.
        rd_src[0] = 8'h10; rd_src[1] = 8'h11; rd_src[2] = 8'h12; rd_cnt = 3;
        ew(1, 8'h01); ew(2, 8'h06); ew(2, 8'h04); ew(1, 8'h45); ew(2, 8'h01);
        ew(2, 8'h02); ew(2, 8'h02); ew(2, 8'h03); ew(2, 8'h05);
        exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'h12);
        issue("rd3", 1'b1, 4'd1, 7'h22, 8'd3);
        finish_txn("rd3", 2'b00);

        // Address NAK: write bytes are on offer but must not be taken.
        wr_src[2] = 8'h77; wr_src[3] = 8'h88; wr_cnt = 4;
        rdy0 = rdy_cnt;
        sp_idx = ncmd + 2; sp_val = 8'hC0;
        ew(1, 8'h00); ew(2, 8'h06); ew(2, 8'h04); ew(1, 8'hA0); ew(2, 8'h01); ew(2, 8'h05);
        issue("anak", 1'b0, 4'd0, 7'h50, 8'd2);
        finish_txn("anak", 2'b01);
        sp_idx = -1;
        check("anak_wr_ready", rdy_cnt, rdy0);
        check("anak_unconsumed", wr_ptr, 2);

        // Reset while waiting for the third write byte.
        base = obs_wr.size();
        ew(1, 8'h04); ew(2, 8'h06); ew(2, 8'h04); ew(1, 8'h12); ew(2, 8'h01);
        ew(1, 8'h77); ew(2, 8'h01); ew(1, 8'h88); ew(2, 8'h01);
        issue("rst", 1'b0, 4'd4, 7'h09, 8'd3);
        n = 0;
        while (obs_wr.size() < base + 9 && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (20) @(negedge clk);
        cmp_writes("rst_pre");
        #2 rst_n = 1'b0;
        #1;
        check("rst_abort_cyc", wb_cyc, 1'b0);
        check("rst_abort_stb", wb_stb, 1'b0);
        check("rst_abort_we", wb_we, 1'b0);
        check("rst_abort_bus", {wb_adr, wb_dat_o}, 10'h000);
        check("rst_abort_status", status, 2'b00);
        check("rst_abort_ready", req_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ew(2'd0, CsrInit);
        wait_ready("rst_reinit");
        repeat (3) @(negedge clk);
        cmp_writes("rst_reinit");
        check("rst_no_done", obs_st.size(), osp);

        // Arbitration lost after START: no STOP.
        sp_idx = ncmd + 1; sp_val = 8'hA0;
        ew(1, 8'h05); ew(2, 8'h06); ew(2, 8'h04);
        issue("al", 1'b0, 4'd5, 7'h11, 8'd1);
        finish_txn("al", 2'b11);
        sp_idx = -1;

        // Single-byte read straight after the abort.
        rd_src[3] = 8'h5A; rd_cnt = 4;
        ew(1, 8'h03); ew(2, 8'h06); ew(2, 8'h04); ew(1, 8'h1F); ew(2, 8'h01);
        ew(2, 8'h03); ew(2, 8'h05);
        exp_rd.push_back(8'h5A);
        issue("rd1", 1'b1, 4'd3, 7'h0F, 8'd1);
        finish_txn("rd1", 2'b00);

        // Zero-length address probe.
        ew(1, 8'h00); ew(2, 8'h06); ew(2, 8'h04); ew(1, 8'h74); ew(2, 8'h01); ew(2, 8'h05);
        issue("probe", 1'b0, 4'd0, 7'h3A, 8'd0);
        finish_txn("probe", 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2cmb_cmd_sequencer.md
Name: i2cmb_cmd_sequencer

Overview:
- Hardware command sequencer that drives the i2cmb Wishbone slave register file (CSR=0, DPR=1, CMDR=2, FSMR=3) to run complete I2C transactions.
- Accepts one transaction request from a host: bus, 7-bit address, direction and length.
- Issues the Wishbone register accesses in the required order, checks each CMDR response, and returns read data and a final status.
- Sits between a host engine and the i2cmb core as the single Wishbone master.

Parameters:
- LEN_W, 8, width of req_len; transfer length 0..2^LEN_W-1 bytes.
- BUS_W, 4, width of req_bus (i2cmb bus select).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  transaction request
- req_ready_o  out  1  sequencer idle, request accepted when both high
- req_rw_i  in  1  0=write, 1=read
- req_bus_i  in  BUS_W  bus id
- req_addr_i  in  7  I2C slave address
- req_len_i  in  LEN_W  byte count; 0 = address-only probe
- wr_data_i  in  8  next write byte
- wr_valid_i  in  1  write byte available
- wr_ready_o  out  1  write byte consumed when both high
- rd_data_o  out  8  read byte
- rd_valid_o  out  1  one-cycle pulse per read byte, no backpressure
- done_o  out  1  one-cycle pulse, transaction finished
- status_o  out  2  00 ok, 01 addr NAK, 10 data NAK, 11 arbitration lost/ERR; valid with done_o, held until next done_o
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  2  register address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack_i  in  1  acknowledge
- irq_i  in  1  i2cmb interrupt (level)

Behaviour:
- Reset: all outputs 0; status_o=00; FSM=INIT. Asserting rst_n_i mid-transaction aborts immediately with no STOP issued and no done_o. INIT runs again after release.
- Wishbone access: cyc/stb/we/adr/dat are asserted together and held until wb_ack_i. The access completes on the ack cycle and all strobes drop on the next cycle. Never back-to-back without one idle cycle. One access outstanding.
- INIT: write CSR=0xC0 (enable, IE), then IDLE.
- IDLE: req_ready_o=1. A request is latched on req_valid_i&req_ready_o, and req_ready_o drops the next cycle.
- Command issue: each command step writes DPR if needed, then writes CMDR, then goes to WAIT_DON.
- WAIT_DON: wait for irq_i=1, then read CMDR (clears irq). Decode bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
- Sequence:
  - SETBUS: DPR=req_bus, CMDR=0x06.
  - START: CMDR=0x04.
  - ADDR: DPR={addr,rw}, CMDR=0x01.
  - Data phase, write: per byte, wait wr_valid_i; wr_ready_o pulses 1 cycle in the cycle the DPR write is launched; then CMDR=0x01.
  - Data phase, read: CMDR=0x02 (ACK) for all but the last byte, 0x03 (NAK) for the last; then read DPR; rd_valid_o pulses on that read's ack cycle+1.
  - STOP: CMDR=0x05.
  - DONE: pulse done_o, then IDLE.
- Response handling:
  - NAK on address: status 01, skip data, go to STOP.
  - NAK on a write byte: status 10, go to STOP. Remaining write bytes are not consumed.
  - NAK on a read step is expected and ignored.
  - AL or ERR at any step: status 11, go directly to DONE with no STOP (bus not owned).
  - DON on the STOP step completes normally.
- Length: req_len=0 → ADDR then STOP. The byte counter counts down and never wraps.
- done_o and req_ready_o are never high in the same cycle.

Optional Feature:
- Macro I2CMB_SEQ_POLL_EN.
- Defined: irq_i is ignored; INIT writes CSR=0x80 (IE off). WAIT_DON repeatedly reads CMDR, with ≥1 idle cycle between reads, until any of bits 7:4 is set.
- Undefined: irq-driven wait as described above.

Test Plan:
- Reset then idle → exactly one WB write adr=0 dat=0xC0; req_ready_o=1.
- Write bus=2, addr=0x22, len=2, data 0xA5,0x3C, slave ACKs all → CMDR/DPR sequence 06,04,DPR 0x44,01,DPR A5,01,DPR 3C,01,05; done_o with status 00.
- Read addr=0x22, len=3, slave returns 0x10,0x11,0x12 → CMDR 02,02,03; three rd_valid_o pulses with those bytes in order; status 00.
- Address NAK (CMDR reads 0xC0 after the addr write) → no data writes; STOP issued; status 01; wr_ready_o never asserted.
- Arbitration lost (CMDR 0xA0 after START) → no STOP; done_o with status 11; next request accepted normally.
- rst_n_i asserted during a data byte wait → all WB outputs 0 asynchronously; after release, CSR=0xC0 rewritten before req_ready_o=1.
